// File: rtl/slot_pkg.sv
// Shared FSM encoding and per-slot position codes for the slot sequencer.
// A position code is a 3-bit one-hot {FINAL, INTERMEDIO, INICIO}, or both ends when the chain is one slot long.
package slot_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WAIT_Q,
        S_HOLD,
        S_ADVANCE,
        S_FINISH,
        S_FAULT
    } state_e;

    localparam int POS_INICIO = 0;
    localparam int POS_INTER  = 1;
    localparam int POS_FINAL  = 2;
    localparam int POS_W      = 3;

    function automatic logic [POS_W-1:0] pos_code(input int unsigned slot, input int unsigned len);
        logic [POS_W-1:0] c;
        c = '0;
        if (slot < len) begin
            if (slot == 0)
                c[POS_INICIO] = 1'b1;
            if (slot == len - 1)
                c[POS_FINAL] = 1'b1;
            if (slot != 0 && slot != len - 1)
                c[POS_INTER] = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/slot_pos_decode.sv
// Combinational decode of chain length into per-slot INICIO/INTERMEDIO/FINAL vectors.
// Zero latency; slots at or beyond the length decode to all-zero.
module slot_pos_decode
    import slot_pkg::*;
#(
    parameter int N_SLOTS = 4
) (
    input  logic [$clog2(N_SLOTS):0] len_i,
    output logic [N_SLOTS-1:0]       inicio_o,
    output logic [N_SLOTS-1:0]       intermedio_o,
    output logic [N_SLOTS-1:0]       final_o
);

    logic [POS_W-1:0] code;

    always_comb begin
        inicio_o     = '0;
        intermedio_o = '0;
        final_o      = '0;
        code         = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            code            = pos_code(i, 32'(len_i));
            inicio_o[i]     = code[POS_INICIO];
            intermedio_o[i] = code[POS_INTER];
            final_o[i]      = code[POS_FINAL];
        end
    end

endmodule

// File: rtl/slot_sequencer.sv
// Steps a chain of slots one at a time: clear, wait for each Q, dwell, advance; timeout or abort resets all slots.
// Control outputs decode from the registered state; position outputs are registered one cycle after an accepted start.
module slot_sequencer
    import slot_pkg::*;
#(
    parameter int N_SLOTS    = 4,
    parameter int TIMEOUT    = 255,
    parameter int CLR_CYCLES = 2
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     start_i,
    input  logic                     abort_i,
    input  logic [$clog2(N_SLOTS):0] len_i,
    input  logic [7:0]               dwell_i,
    input  logic [N_SLOTS-1:0]       slot_q_i,
    output logic [N_SLOTS-1:0]       inicio_o,
    output logic [N_SLOTS-1:0]       intermedio_o,
    output logic [N_SLOTS-1:0]       final_o,
    output logic [N_SLOTS-1:0]       slot_rst_o,
    output logic [N_SLOTS-1:0]       step_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o
);

    localparam int LW    = $clog2(N_SLOTS) + 1;
    localparam int IW    = $clog2(N_SLOTS);
    localparam int CMAX0 = (TIMEOUT > 255) ? TIMEOUT : 255;
    localparam int CMAX  = (CMAX0 > CLR_CYCLES) ? CMAX0 : CLR_CYCLES;
    localparam int CW    = $clog2(CMAX + 1);

    state_e               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [LW-1:0]        len_q, len_d;
    logic [7:0]           dwell_q, dwell_d;
    logic                 err_q, err_d;
    logic [N_SLOTS-1:0]   inicio_q, inicio_d, inter_q, inter_d, final_q, final_d;
    logic [N_SLOTS-1:0]   dec_inicio, dec_inter, dec_final, clr_mask;
    logic                 len_ok, accept, q_cur, last_idx;

    slot_pos_decode #(.N_SLOTS(N_SLOTS)) u_pos_decode (
        .len_i        (len_i),
        .inicio_o     (dec_inicio),
        .intermedio_o (dec_inter),
        .final_o      (dec_final)
    );

    assign len_ok   = (len_i != '0) && (len_i <= LW'(N_SLOTS));
    assign accept   = (state_q == S_IDLE) && start_i && !abort_i && len_ok;
    assign q_cur    = slot_q_i[idx_q];
    assign last_idx = ({1'b0, idx_q} == (len_q - LW'(1)));

    always_comb begin
        clr_mask = '0;
        for (int i = 0; i < N_SLOTS; i++)
            clr_mask[i] = (LW'(i) < len_q);
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        dwell_d    = dwell_q;
        err_d      = err_q;
        inicio_d   = inicio_q;
        inter_d    = inter_q;
        final_d    = final_q;
        step_o     = '0;
        slot_rst_o = '0;
        done_o     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d  = S_CLEAR;
                    cnt_d    = '0;
                    len_d    = len_i;
                    dwell_d  = dwell_i;
                    err_d    = 1'b0;
                    inicio_d = dec_inicio;
                    inter_d  = dec_inter;
                    final_d  = dec_final;
                end
            end
            S_CLEAR: begin
                slot_rst_o = clr_mask;
                if (cnt_q == CW'(CLR_CYCLES - 1)) begin
                    state_d = S_WAIT_Q;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT_Q: begin
                step_o = N_SLOTS'(1) << idx_q;
                // Q beats the timeout when both land in the same cycle.
                if (q_cur) begin
                    cnt_d   = '0;
                    state_d = (dwell_q == '0) ? S_ADVANCE : S_HOLD;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = S_FAULT;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_HOLD: begin
                step_o = N_SLOTS'(1) << idx_q;
                if (!q_cur) begin
                    state_d = S_WAIT_Q;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(dwell_q) - CW'(1)) begin
                    state_d = S_ADVANCE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_ADVANCE: begin
                cnt_d = '0;
                if (last_idx) begin
                    state_d = S_FINISH;
                end else begin
                    state_d = S_WAIT_Q;
                    idx_d   = idx_q + IW'(1);
                end
            end
            S_FINISH: begin
                done_o  = !abort_i;
                state_d = S_IDLE;
            end
            S_FAULT: begin
                slot_rst_o = '1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides every transition but never touches the error flag.
        if (abort_i && state_q != S_IDLE && state_q != S_FAULT) begin
            state_d = S_FAULT;
            err_d   = err_q;
        end

        if (state_d == S_IDLE) begin
            idx_d    = '0;
            cnt_d    = '0;
            inicio_d = '0;
            inter_d  = '0;
            final_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            len_q    <= '0;
            dwell_q  <= '0;
            err_q    <= 1'b0;
            inicio_q <= '0;
            inter_q  <= '0;
            final_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            dwell_q  <= dwell_d;
            err_q    <= err_d;
            inicio_q <= inicio_d;
            inter_q  <= inter_d;
            final_q  <= final_d;
        end
    end

    assign busy_o       = (state_q != S_IDLE);
    assign err_o        = err_q;
    assign inicio_o     = inicio_q;
    assign intermedio_o = inter_q;
    assign final_o      = final_q;

endmodule

// File: tb/tb_slot_sequencer.sv
// Directed bench for slot_sequencer with a behavioural slot model and a queue of expected STEP tokens.
module tb_slot_sequencer;

    localparam int N   = 4;
    localparam int TO  = 10;
    localparam int CLR = 2;

    logic         clk = 1'b0;
    logic         reset, start, abort;
    logic [2:0]   len;
    logic [7:0]   dwell;
    logic [N-1:0] model_q, q_kill, slot_q;
    logic [N-1:0] inicio, inter, fin, slot_rst, step;
    logic         busy, done, err;

    int           checks = 0;
    int           errors = 0;
    int           done_cnt = 0;
    int           d0;
    logic [N-1:0] exp_step[$];
    logic [N-1:0] prev_step;
    logic         mon_en = 1'b0;
    logic         q_auto = 1'b0;
    int           q_delay = 3;
    int           qcnt[N];

    assign slot_q = model_q & ~q_kill;

    slot_sequencer #(.N_SLOTS(N), .TIMEOUT(TO), .CLR_CYCLES(CLR)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .start_i      (start),
        .abort_i      (abort),
        .len_i        (len),
        .dwell_i      (dwell),
        .slot_q_i     (slot_q),
        .inicio_o     (inicio),
        .intermedio_o (inter),
        .final_o      (fin),
        .slot_rst_o   (slot_rst),
        .step_o       (step),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic go(input logic [2:0] l, input logic [7:0] d);
        len   = l;
        dwell = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int maxc);
        int n;
        n = 0;
        while (busy && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, busy, 0);
    endtask

    task automatic wait_q(input string tag, input int idx, input int maxc);
        int n;
        n = 0;
        while (!slot_q[idx] && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_q_rise"}, slot_q[idx], 1);
    endtask

    // Slot model: Q rises q_delay cycles after its STEP bit, cleared by SLOT_RST.
    initial begin
        model_q = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (slot_rst[i]) begin
                    model_q[i] = 1'b0;
                    qcnt[i]    = 0;
                end else if (q_auto && step[i] && !model_q[i]) begin
                    qcnt[i]++;
                    if (qcnt[i] >= q_delay)
                        model_q[i] = 1'b1;
                end else if (!step[i]) begin
                    qcnt[i] = 0;
                end
            end
        end
    end

    // Every new STEP token is popped against the expected order.
    initial begin
        prev_step = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("step_onehot", 32'($countones(step) <= 1), 1);
                if (step != '0 && step != prev_step) begin
                    if (exp_step.size() == 0)
                        chk("step_unexpected", step, 0);
                    else
                        chk("step_order", step, exp_step.pop_front());
                end
                if (done)
                    done_cnt++;
            end
            prev_step = step;
        end
    end

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        len    = 3'd0;
        dwell  = 8'd0;
        q_kill = '0;
        tick(2);
        chk("rst_busy", busy, 0);
        chk("rst_step", step, 0);
        chk("rst_slot_rst", slot_rst, 0);
        chk("rst_pos", {inicio, inter, fin}, 0);
        chk("rst_done_err", {done, err}, 0);
        reset  = 1'b0;
        mon_en = 1'b1;
        q_auto = 1'b1;
        tick(1);

        // Three-slot chain; inputs changed after start must not matter.
        exp_step.push_back(4'b0001);
        exp_step.push_back(4'b0010);
        exp_step.push_back(4'b0100);
        d0 = done_cnt;
        go(3'd3, 8'd2);
        chk("l3_inicio", inicio, 4'b0001);
        chk("l3_inter", inter, 4'b0010);
        chk("l3_final", fin, 4'b0100);
        chk("l3_clear_rst", slot_rst, 4'b0111);
        chk("l3_busy", busy, 1);
        len   = 3'd1;
        dwell = 8'd0;
        wait_idle("l3", 200);
        chk("l3_done", done_cnt - d0, 1);
        chk("l3_err", err, 0);
        chk("l3_pos_idle", {inicio, inter, fin}, 0);

        // Single-slot chain.
        exp_step.push_back(4'b0001);
        d0 = done_cnt;
        go(3'd1, 8'd0);
        chk("l1_inicio", inicio, 4'b0001);
        chk("l1_inter", inter, 4'b0000);
        chk("l1_final", fin, 4'b0001);
        wait_idle("l1", 100);
        chk("l1_done", done_cnt - d0, 1);

        // Q arriving in the last allowed WAIT_Q cycle still succeeds.
        q_delay = TO;
        exp_step.push_back(4'b0001);
        d0 = done_cnt;
        go(3'd1, 8'd0);
        wait_idle("edge", 100);
        chk("edge_done", done_cnt - d0, 1);
        chk("edge_err", err, 0);

        // Timeout: Q never arrives.
        q_auto = 1'b0;
        exp_step.push_back(4'b0001);
        d0 = done_cnt;
        go(3'd2, 8'd1);
        begin
            int n;
            n = 0;
            while (step != 4'b0001 && n < 10) begin
                tick(1);
                n++;
            end
            n = 0;
            while (step == 4'b0001 && n < 50) begin
                tick(1);
                n++;
            end
            chk("to_wait_cycles", n, TO);
        end
        chk("to_slot_rst", slot_rst, 4'b1111);
        chk("to_err", err, 1);
        chk("to_busy", busy, 1);
        tick(1);
        chk("to_idle", busy, 0);
        chk("to_rst_one_cycle", slot_rst, 0);
        tick(3);
        chk("to_err_sticky", err, 1);
        chk("to_no_done", done_cnt - d0, 0);

        // Illegal lengths and start-with-abort are ignored, error kept.
        len = 3'd0; start = 1'b1; tick(2); start = 1'b0;
        chk("len0_idle", busy, 0);
        chk("len0_err", err, 1);
        len = 3'd5; start = 1'b1; tick(2); start = 1'b0;
        chk("len5_idle", busy, 0);
        chk("len5_err", err, 1);
        len = 3'd2; start = 1'b1; abort = 1'b1; tick(2); start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", busy, 0);
        chk("start_abort_pos", inicio, 0);

        // Next accepted start clears the error.
        q_auto  = 1'b1;
        q_delay = 3;
        exp_step.push_back(4'b0001);
        d0 = done_cnt;
        go(3'd1, 8'd0);
        chk("errclr_err", err, 0);
        wait_idle("errclr", 100);
        chk("errclr_done", done_cnt - d0, 1);

        // Abort while holding slot 1.
        q_delay = 2;
        exp_step.push_back(4'b0001);
        exp_step.push_back(4'b0010);
        d0 = done_cnt;
        go(3'd3, 8'd20);
        wait_q("abort", 1, 100);
        tick(2);
        chk("abort_hold_step", step, 4'b0010);
        abort = 1'b1;
        tick(1);
        chk("abort_slot_rst", slot_rst, 4'b1111);
        chk("abort_step", step, 0);
        abort = 1'b0;
        tick(1);
        chk("abort_idle", busy, 0);
        chk("abort_rst_one_cycle", slot_rst, 0);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_err", err, 0);

        // Q drops mid-hold: back to waiting on the same slot.
        exp_step.push_back(4'b0001);
        exp_step.push_back(4'b0010);
        d0 = done_cnt;
        go(3'd2, 8'd6);
        wait_q("drop", 0, 100);
        tick(3);
        q_kill = 4'b0001;
        tick(1);
        chk("drop_step", step, 4'b0001);
        tick(4);
        chk("drop_still_waiting", step, 4'b0001);
        chk("drop_busy", busy, 1);
        q_kill = '0;
        wait_idle("drop", 200);
        chk("drop_done", done_cnt - d0, 1);
        chk("drop_err", err, 0);

        // Reset mid-WAIT_Q overrides abort and start.
        q_auto = 1'b0;
        exp_step.push_back(4'b0001);
        go(3'd4, 8'd0);
        tick(3);
        chk("rmid_step", step, 4'b0001);
        chk("rmid_pos", {inicio, inter, fin}, {4'b0001, 4'b0110, 4'b1000});
        reset = 1'b1;
        abort = 1'b1;
        start = 1'b1;
        tick(1);
        chk("rmid_step0", step, 0);
        chk("rmid_busy", busy, 0);
        chk("rmid_slot_rst", slot_rst, 0);
        chk("rmid_pos0", {inicio, inter, fin}, 0);
        chk("rmid_done_err", {done, err}, 0);
        reset = 1'b0;
        abort = 1'b0;
        start = 1'b0;
        tick(2);
        chk("queue_empty", exp_step.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/slot_sequencer.md
SLOT_SEQUENCER -- requirements
Module: slot_sequencer

Interface
REQ-001 SHALL have parameter N_SLOTS, default 4, meaning the number of chained slots controlled (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the maximum cycles to wait for a slot Q before error.
REQ-003 SHALL have parameter CLR_CYCLES, default 2, meaning the number of cycles SLOT_RST is held at sequence start.
REQ-004 CLK  in  1  single clock; all state updates on rising edge.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 START  in  1  level; sampled only in IDLE; begins a sequence.
REQ-007 ABORT  in  1  level; terminates any active sequence.
REQ-008 LEN  in  clog2(N_SLOTS)+1  number of active slots; legal range 1..N_SLOTS.
REQ-009 DWELL  in  8  minimum hold cycles after each slot's Q rises.
REQ-010 SLOT_Q  in  N_SLOTS  Q output of each slot, bit i = slot i.
REQ-011 INICIO, INTERMEDIO, FINAL  out  N_SLOTS each  per-slot position configuration.
REQ-012 SLOT_RST  out  N_SLOTS  per-slot reset drive.
REQ-013 STEP  out  N_SLOTS  one-hot active-slot token; all-zero when not stepping.
REQ-014 BUSY  out  1  high in every state except IDLE.
REQ-015 DONE  out  1  one-cycle pulse on successful completion.
REQ-016 ERR  out  1  sticky timeout flag; cleared by RESET or the next accepted START.

Function
REQ-017 START in IDLE with LEN outside 1..N_SLOTS SHALL be ignored (no state change, ERR unchanged).
REQ-018 Accepted START SHALL latch LEN and DWELL; later input changes SHALL not affect the running sequence.
REQ-019 Position config from latched LEN: slot 0 INICIO; slots 1..LEN-2 INTERMEDIO; slot LEN-1 FINAL; slots >= LEN all zero.
REQ-020 LEN=1 SHALL set both INICIO[0] and FINAL[0].
REQ-021 Position outputs SHALL be registered, valid from the cycle after START, held until return to IDLE, zero in IDLE.
REQ-022 FSM states: IDLE, CLEAR, WAIT_Q, HOLD, ADVANCE, FINISH, FAULT.
REQ-023 IDLE -> CLEAR on accepted START; CLEAR drives SLOT_RST[LEN-1:0] high for exactly CLR_CYCLES cycles, then -> WAIT_Q with index 0.
REQ-024 WAIT_Q drives STEP[idx]=1; on SLOT_Q[idx]=1 -> HOLD; after TIMEOUT cycles without it -> FAULT.
REQ-025 Timeout counter SHALL reset on WAIT_Q entry; SLOT_Q sampled high in the same cycle the counter reaches TIMEOUT counts as success.
REQ-026 HOLD keeps STEP[idx]=1 for DWELL cycles (DWELL=0 means zero extra cycles), then -> ADVANCE; if SLOT_Q[idx] falls during HOLD -> WAIT_Q (counter restarts).
REQ-027 ADVANCE (one cycle, STEP zero): idx=LEN-1 -> FINISH, else idx+1 -> WAIT_Q.
REQ-028 FINISH pulses DONE for one cycle -> IDLE.
REQ-029 FAULT sets ERR, drives SLOT_RST all-ones for one cycle -> IDLE.
REQ-030 ABORT in any non-IDLE state SHALL take priority over all transitions: one cycle of SLOT_RST all-ones, then IDLE; no DONE, ERR unchanged.
REQ-031 START and ABORT high together in IDLE: START SHALL be ignored.
REQ-032 STEP SHALL never have more than one bit set.

Reset
REQ-033 RESET SHALL force IDLE, idx=0, counters 0, ERR=0, DONE=0, STEP/INICIO/INTERMEDIO/FINAL/SLOT_RST=0, BUSY=0, and SHALL override ABORT and START in the same cycle, including mid-sequence.

Structure
REQ-034 State encoding and position-bit constants SHALL live in shared package slot_pkg.
REQ-035 Position decode (LEN -> INICIO/INTERMEDIO/FINAL vectors) SHALL be one combinational sub-module, slot_pos_decode, registered in slot_sequencer.

Verification
REQ-036 LEN=3, DWELL=2, SLOT_Q[i] raised 3 cycles after STEP[i] -> STEP 001,010,100 in order, INICIO=001, INTERMEDIO=010, FINAL=100, one DONE pulse, ERR=0.
REQ-037 LEN=1 -> INICIO[0]=FINAL[0]=1, others 0; DONE after single step.
REQ-038 TIMEOUT=10, SLOT_Q held 0 -> FAULT at cycle 10 of WAIT_Q, ERR=1 sticky, SLOT_RST=all-ones one cycle, no DONE.
REQ-039 ABORT during HOLD of slot 1 -> SLOT_RST all-ones one cycle, IDLE, BUSY=0, no DONE.
REQ-040 SLOT_Q[0] drops mid-HOLD -> return to WAIT_Q, STEP stays 0001, sequence completes after Q returns.
REQ-041 LEN=0 or LEN=N_SLOTS+1 with START -> stays IDLE; RESET mid-WAIT_Q -> all outputs 0 next cycle.
